// File: rtl/vexec_pkg.sv
// Shared types for the vector execute stage: opcode and FSM state encodings.
package vexec_pkg;

    typedef enum logic [3:0] {
        ADD = 4'd0,
        SUB = 4'd1,
        AND = 4'd2,
        OR  = 4'd3,
        XOR = 4'd4,
        SLL = 4'd5,
        SRL = 4'd6,
        MOV = 4'd7,
        MUL = 4'd8
    } vexec_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } vexec_state_t;

endpackage

// File: rtl/vexec_lane.sv
// One lane of the execute stage: combinational ALU plus, when VEXEC_MUL_EN is
// defined, an iterative shift-add multiplier retiring one multiplier bit per cycle.
module vexec_lane
    import vexec_pkg::*;
#(
    parameter int registerSize = 8
) (
`ifdef VEXEC_MUL_EN
    input  logic                    clk,
    input  logic                    mul_load_i,
    input  logic                    mul_step_i,
    output logic [registerSize-1:0] mul_o,
`endif
    input  vexec_op_t               op_i,
    input  logic [registerSize-1:0] a_i,
    input  logic [registerSize-1:0] b_i,
    output logic [registerSize-1:0] alu_o
);

    // Shifts by the full lane value: amounts >= registerSize naturally yield 0.
    always_comb begin
        alu_o = '0;
        case (op_i)
            ADD:     alu_o = a_i + b_i;
            SUB:     alu_o = a_i - b_i;
            AND:     alu_o = a_i & b_i;
            OR:      alu_o = a_i | b_i;
            XOR:     alu_o = a_i ^ b_i;
            SLL:     alu_o = a_i << b_i;
            SRL:     alu_o = a_i >> b_i;
            MOV:     alu_o = a_i;
            default: alu_o = '0;
        endcase
    end

`ifdef VEXEC_MUL_EN
    logic [registerSize-1:0] acc_q, acc_d;
    logic [registerSize-1:0] mcand_q, mcand_d;
    logic [registerSize-1:0] mplier_q, mplier_d;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (mul_load_i) begin
            acc_d    = '0;
            mcand_d  = a_i;
            mplier_d = b_i;
        end else if (mul_step_i) begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
        end
    end

    always_ff @(posedge clk) begin
        acc_q    <= acc_d;
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
    end

    assign mul_o = acc_q;
`endif

endmodule

// File: rtl/vector_execute_stage.sv
// Vector execute stage: lane-wise ALU and (with VEXEC_MUL_EN) multi-cycle MUL,
// valid/ready handshake on both sides, registered results for write-back.
module vector_execute_stage
    import vexec_pkg::*;
#(
    parameter int registerSize = 8,
    parameter int vectorSize   = 4,
    parameter int regAddrBits  = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [3:0]                         op,
    input  logic                               isVec,
    input  logic                               useImm,
    input  logic [registerSize-1:0]            imm,
    input  logic [vectorSize*registerSize-1:0] operand1,
    input  logic [vectorSize*registerSize-1:0] operand2,
    input  logic [regAddrBits-1:0]             regToWrite,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [vectorSize*registerSize-1:0] result,
    output logic [regAddrBits-1:0]             out_reg,
    output logic                               regWrEnSc,
    output logic                               regWrEnVec,
    output logic                               zeroFlag
);

    localparam int VW = vectorSize * registerSize;

    vexec_state_t state_q, state_d;
    vexec_op_t    op_e;
    logic         accept;
    logic         start_mul;
    logic         mul_done;

    logic [VW-1:0]          alu_vec, alu_masked;
    logic [VW-1:0]          result_q, result_d;
    logic [regAddrBits-1:0] out_reg_q, out_reg_d;
    logic                   isVec_q, isVec_d;
    logic                   zero_q, zero_d;

    assign op_e   = vexec_op_t'(op);
    assign accept = in_valid & in_ready;

`ifdef VEXEC_MUL_EN
    localparam int CNT_W = $clog2(registerSize + 1);

    logic [VW-1:0]    mul_vec, mul_masked;
    logic [CNT_W-1:0] cnt_q;
    logic             mul_step;

    assign start_mul = (op_e == MUL);
    assign mul_done  = (state_q == BUSY) && (cnt_q == CNT_W'(registerSize));
    assign mul_step  = (state_q == BUSY) && !mul_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (accept && start_mul) begin
            cnt_q <= '0;
        end else if (mul_step) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    assign start_mul = 1'b0;
    assign mul_done  = 1'b0;
`endif

    for (genvar g = 0; g < vectorSize; g++) begin : g_lane
        logic [registerSize-1:0] b_eff;
        assign b_eff = useImm ? imm : operand2[g*registerSize +: registerSize];

        vexec_lane #(.registerSize(registerSize)) u_lane (
`ifdef VEXEC_MUL_EN
            .clk        (clk),
            .mul_load_i (accept && start_mul),
            .mul_step_i (mul_step),
            .mul_o      (mul_vec[g*registerSize +: registerSize]),
`endif
            .op_i       (op_e),
            .a_i        (operand1[g*registerSize +: registerSize]),
            .b_i        (b_eff),
            .alu_o      (alu_vec[g*registerSize +: registerSize])
        );

        // Scalar ops only drive lane 0; upper lanes read back as zero.
        assign alu_masked[g*registerSize +: registerSize] =
            (isVec || g == 0) ? alu_vec[g*registerSize +: registerSize] : '0;
`ifdef VEXEC_MUL_EN
        assign mul_masked[g*registerSize +: registerSize] =
            (isVec_q || g == 0) ? mul_vec[g*registerSize +: registerSize] : '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = start_mul ? BUSY : HOLD;
            BUSY: if (mul_done) state_d = HOLD;
            HOLD: if (out_ready) state_d = accept ? (start_mul ? BUSY : HOLD) : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = !rst && ((state_q == IDLE) || ((state_q == HOLD) && out_ready));
        out_valid  = (state_q == HOLD);
        regWrEnSc  = out_valid && !isVec_q;
        regWrEnVec = out_valid && isVec_q;
    end

    // Output registers only move on accept or multiply completion, so they hold under backpressure.
    always_comb begin
        result_d  = result_q;
        out_reg_d = out_reg_q;
        isVec_d   = isVec_q;
        if (accept) begin
            out_reg_d = regToWrite;
            isVec_d   = isVec;
            if (!start_mul) begin
                result_d = alu_masked;
            end
        end
`ifdef VEXEC_MUL_EN
        if (mul_done) begin
            result_d = mul_masked;
        end
`endif
        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q  <= '0;
            out_reg_q <= '0;
            isVec_q   <= 1'b0;
            zero_q    <= 1'b1;
        end else begin
            result_q  <= result_d;
            out_reg_q <= out_reg_d;
            isVec_q   <= isVec_d;
            zero_q    <= zero_d;
        end
    end

    assign result   = result_q;
    assign out_reg  = out_reg_q;
    assign zeroFlag = zero_q;

endmodule

// File: tb/tb_vector_execute_stage.sv
// Directed bench for vector_execute_stage; MUL expectations follow VEXEC_MUL_EN.
module tb_vector_execute_stage;
    import vexec_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic        isVec;
    logic        useImm;
    logic [7:0]  imm;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [3:0]  regToWrite;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  out_reg;
    logic        regWrEnSc;
    logic        regWrEnVec;
    logic        zeroFlag;

    int n_tests = 0;
    int n_fail  = 0;

    vector_execute_stage #(.registerSize(8), .vectorSize(4), .regAddrBits(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .isVec      (isVec),
        .useImm     (useImm),
        .imm        (imm),
        .operand1   (operand1),
        .operand2   (operand2),
        .regToWrite (regToWrite),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .out_reg    (out_reg),
        .regWrEnSc  (regWrEnSc),
        .regWrEnVec (regWrEnVec),
        .zeroFlag   (zeroFlag)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] o, input logic v, input logic ui, input logic [7:0] im,
                         input logic [31:0] a, input logic [31:0] b, input logic [3:0] rd);
        in_valid   = 1'b1;
        op         = o;
        isVec      = v;
        useImm     = ui;
        imm        = im;
        operand1   = a;
        operand2   = b;
        regToWrite = rd;
    endtask

    initial begin
        int k;
        logic [31:0] held_res;
        logic [31:0] exp_res;
        logic        stale;

        rst = 1'b1; in_valid = 1'b0; op = 4'd0; isVec = 1'b0; useImm = 1'b0; imm = 8'd0;
        operand1 = '0; operand2 = '0; regToWrite = '0; out_ready = 1'b1;
        tick(); tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_out_reg", out_reg, 0);
        chk("rst_zero", zeroFlag, 1);
        chk("rst_wren", {regWrEnSc, regWrEnVec}, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // vector ADD with lane0 wrap
        drive(ADD, 1'b1, 1'b0, 8'h00, 32'h030201FF, 32'h01010101, 4'd3);
        tick();
        in_valid = 1'b0;
        chk("add_valid", out_valid, 1);
        chk("add_result", result, 32'h04030200);
        chk("add_wren", {regWrEnSc, regWrEnVec}, 2'b01);
        chk("add_zero", zeroFlag, 0);
        chk("add_reg", out_reg, 3);
        tick();
        chk("add_drain", out_valid, 0);

        // scalar SUB with immediate, underflow in lane 0
        drive(SUB, 1'b0, 1'b1, 8'h05, 32'hAABBCC03, 32'h11111111, 4'd5);
        tick();
        in_valid = 1'b0;
        chk("sub_result", result, 32'h000000FE);
        chk("sub_wren", {regWrEnSc, regWrEnVec}, 2'b10);
        chk("sub_reg", out_reg, 5);
        tick();

        // vector MUL
        drive(MUL, 1'b1, 1'b0, 8'h00, 32'h00FF1003, 32'h07021005, 4'd7);
        tick();
        in_valid = 1'b0;
`ifdef VEXEC_MUL_EN
        k = 0;
        while (!out_valid && k < 20) begin
            chk("mul_busy_in_ready", in_ready, 0);
            tick();
            k++;
        end
        chk("mul_latency", k, 9);
        chk("mul_result", result, 32'h00FE000F);
        chk("mul_reg", out_reg, 7);
`else
        chk("mul_undef_valid", out_valid, 1);
        chk("mul_undef_result", result, 0);
        chk("mul_undef_zero", zeroFlag, 1);
`endif
        tick();

        // shifts: amounts 9 and 8 clear the lane
        drive(SLL, 1'b1, 1'b0, 8'h00, 32'hFFFFFFFF, 32'h08000109, 4'd1);
        tick();
        chk("sll_result", result, 32'h00FFFE00);
        drive(SRL, 1'b1, 1'b0, 8'h00, 32'h80808080, 32'h07000108, 4'd2);
        tick();
        chk("srl_result", result, 32'h01804000);
        drive(AND, 1'b1, 1'b0, 8'h00, 32'hF0F0FF00, 32'h3C3C0FFF, 4'd2);
        tick();
        chk("and_result", result, 32'h30300F00);
        drive(OR, 1'b1, 1'b0, 8'h00, 32'hF0000001, 32'h0F000010, 4'd2);
        tick();
        chk("or_result", result, 32'hFF000011);
        drive(XOR, 1'b1, 1'b0, 8'h00, 32'hFF00AA55, 32'h0F0FFF55, 4'd2);
        tick();
        chk("xor_result", result, 32'hF00F5500);
        drive(MOV, 1'b1, 1'b0, 8'h00, 32'hDEADBEEF, 32'h12345678, 4'd2);
        tick();
        chk("mov_result", result, 32'hDEADBEEF);
        drive(4'hF, 1'b1, 1'b0, 8'h00, 32'hDEADBEEF, 32'h12345678, 4'd9);
        tick();
        chk("undef_valid", out_valid, 1);
        chk("undef_result", result, 0);
        chk("undef_reg", out_reg, 9);

        // ten back-to-back ADDs, one result per cycle
        for (int i = 0; i < 10; i++) begin
            drive(ADD, 1'b1, 1'b1, 8'h10, {4{8'(i)}}, 32'h0, 4'(i));
            chk("b2b_in_ready", in_ready, 1);
            tick();
            exp_res = {4{8'(i + 16)}};
            chk("b2b_valid", out_valid, 1);
            chk("b2b_result", result, exp_res);
            chk("b2b_reg", out_reg, i);
        end
        in_valid = 1'b0;
        tick();
        chk("b2b_drain", out_valid, 0);

        // backpressure: HOLD with out_ready low for three cycles
        out_ready = 1'b0;
        drive(XOR, 1'b1, 1'b0, 8'h00, 32'h12345678, 32'hFFFFFFFF, 4'd11);
        tick();
        held_res = 32'hEDCBA987;
        drive(ADD, 1'b1, 1'b0, 8'h00, 32'h01010101, 32'h01010101, 4'd4);
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_result", result, held_res);
            chk("bp_reg", out_reg, 11);
            chk("bp_in_ready", in_ready, 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", in_ready, 1);
        tick();
        chk("bp_drain", out_valid, 0);

        // reset in the middle of work; nothing stale may appear afterwards
`ifdef VEXEC_MUL_EN
        drive(MUL, 1'b1, 1'b0, 8'h00, 32'h05050505, 32'h03030303, 4'd6);
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick(); tick();
`else
        out_ready = 1'b0;
        drive(MOV, 1'b1, 1'b0, 8'h00, 32'h0F0F0F0F, 32'h0, 4'd6);
        tick();
        in_valid = 1'b0;
        tick();
`endif
        rst = 1'b1;
        #1;
        chk("midrst_in_ready_low", in_ready, 0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_result", result, 0);
        chk("midrst_zero", zeroFlag, 1);
        stale = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) stale = 1'b1;
        end
        chk("midrst_no_stale", stale, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
